// File: rtl/id_ex_reg_pkg.sv
// Shared CPU package: field widths, ALU op classes and the ID/EX control bundle.
// Imported by the ID/EX pipeline register and its control sub-register.
package id_ex_reg_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_RTYPE = 2'b10,
      ALU_LOGIC = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       ext_op;
      logic       mem_read;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_reg_ctrl.sv
// Control half of the ID/EX register: clear on reset/flush, hold on stall.
// Carries the ten decoded control fields as one packed word.
module id_ex_ctrl_reg
   import id_ex_reg_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              hold_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i)
         ctrl_o <= '0;
      else if (!hold_i)
         ctrl_o <= ctrl_i;
   end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and a saturating bubble counter.
// Priority per cycle: reset, flush, stall, load.
module id_ex_reg
   import id_ex_reg_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              hazard_i,
   input  logic              RegDst_i,
   input  logic              ALUSrc_i,
   input  logic              MemtoReg_i,
   input  logic              RegWrite_i,
   input  logic              MemWrite_i,
   input  logic              Branch_i,
   input  logic              Jump_i,
   input  logic              ExtOp_i,
   input  logic              MemRead_i,
   input  logic [1:0]        ALUOp_i,
   input  logic [DATA_W-1:0] pc4_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              RegDst_o,
   output logic              ALUSrc_o,
   output logic              MemtoReg_o,
   output logic              RegWrite_o,
   output logic              MemWrite_o,
   output logic              Branch_o,
   output logic              Jump_o,
   output logic              ExtOp_o,
   output logic              MemRead_o,
   output logic [1:0]        ALUOp_o,
   output logic [DATA_W-1:0] pc4_o,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [ADDR_W-1:0] rs_addr_o,
   output logic [ADDR_W-1:0] rt_addr_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   output logic              valid_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;
   logic  bubble;

   always_comb begin
      ctrl_d            = '0;
      ctrl_d.reg_dst    = RegDst_i;
      ctrl_d.alu_src    = ALUSrc_i;
      ctrl_d.mem_to_reg = MemtoReg_i;
      ctrl_d.reg_write  = RegWrite_i;
      ctrl_d.mem_write  = MemWrite_i;
      ctrl_d.branch     = Branch_i;
      ctrl_d.jump       = Jump_i;
      ctrl_d.ext_op     = ExtOp_i;
      ctrl_d.mem_read   = MemRead_i;
      ctrl_d.alu_op     = ALUOp_i;
   end

   id_ex_ctrl_reg u_ctrl (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (flush_i),
      .hold_i (stall_i),
      .ctrl_i (ctrl_d),
      .ctrl_o (ctrl_q)
   );

   assign RegDst_o   = ctrl_q.reg_dst;
   assign ALUSrc_o   = ctrl_q.alu_src;
   assign MemtoReg_o = ctrl_q.mem_to_reg;
   assign RegWrite_o = ctrl_q.reg_write;
   assign MemWrite_o = ctrl_q.mem_write;
   assign Branch_o   = ctrl_q.branch;
   assign Jump_o     = ctrl_q.jump;
   assign ExtOp_o    = ctrl_q.ext_op;
   assign MemRead_o  = ctrl_q.mem_read;
   assign ALUOp_o    = ctrl_q.alu_op;

   // flush and hazard together still make one bubble
   assign bubble = flush_i || (!stall_i && hazard_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc4_o     <= '0;
         rs_data_o <= '0;
         rt_data_o <= '0;
         imm_o     <= '0;
         rs_addr_o <= '0;
         rt_addr_o <= '0;
         rd_addr_o <= '0;
         valid_o   <= 1'b0;
      end else if (flush_i) begin
         pc4_o     <= '0;
         rs_data_o <= '0;
         rt_data_o <= '0;
         imm_o     <= '0;
         rs_addr_o <= '0;
         rt_addr_o <= '0;
         rd_addr_o <= '0;
         valid_o   <= 1'b0;
      end else if (!stall_i) begin
         pc4_o     <= pc4_i;
         rs_data_o <= rs_data_i;
         rt_data_o <= rt_data_i;
         imm_o     <= imm_i;
         rs_addr_o <= rs_addr_i;
         rt_addr_o <= rt_addr_i;
         rd_addr_o <= rd_addr_i;
         valid_o   <= !hazard_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         bubble_cnt_o <= '0;
      else if (bubble && (bubble_cnt_o != '1))
         bubble_cnt_o <= bubble_cnt_o + 1'b1;
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: load, stall, flush, hazard counting,
// counter saturation and reset during stall.
module tb_id_ex_reg;

   logic        clk_i = 1'b0;
   logic        rst_i, stall_i, flush_i, hazard_i;
   logic        RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemWrite_i;
   logic        Branch_i, Jump_i, ExtOp_i, MemRead_i;
   logic [1:0]  ALUOp_i;
   logic [31:0] pc4_i, rs_data_i, rt_data_i, imm_i;
   logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
   logic        RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o, MemWrite_o;
   logic        Branch_o, Jump_o, ExtOp_o, MemRead_o;
   logic [1:0]  ALUOp_o;
   logic [31:0] pc4_o, rs_data_o, rt_data_o, imm_o;
   logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
   logic        valid_o;
   logic [15:0] bubble_cnt_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   id_ex_reg dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
      .flush_i(flush_i), .hazard_i(hazard_i),
      .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i),
      .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
      .MemWrite_i(MemWrite_i), .Branch_i(Branch_i),
      .Jump_i(Jump_i), .ExtOp_i(ExtOp_i),
      .MemRead_i(MemRead_i), .ALUOp_i(ALUOp_i),
      .pc4_i(pc4_i), .rs_data_i(rs_data_i),
      .rt_data_i(rt_data_i), .imm_i(imm_i),
      .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
      .rd_addr_i(rd_addr_i),
      .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o),
      .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
      .MemWrite_o(MemWrite_o), .Branch_o(Branch_o),
      .Jump_o(Jump_o), .ExtOp_o(ExtOp_o),
      .MemRead_o(MemRead_o), .ALUOp_o(ALUOp_o),
      .pc4_o(pc4_o), .rs_data_o(rs_data_o),
      .rt_data_o(rt_data_o), .imm_o(imm_o),
      .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o),
      .rd_addr_o(rd_addr_o),
      .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      rst_i = 0; stall_i = 0; flush_i = 0; hazard_i = 0;
      RegDst_i = 0; ALUSrc_i = 0; MemtoReg_i = 0; RegWrite_i = 0;
      MemWrite_i = 0; Branch_i = 0; Jump_i = 0; ExtOp_i = 0;
      MemRead_i = 0; ALUOp_i = 2'b00;
      pc4_i = 0; rs_data_i = 0; rt_data_i = 0; imm_i = 0;
      rs_addr_i = 0; rt_addr_i = 0; rd_addr_i = 0;
   endtask

   task automatic load_a5();
      idle_inputs();
      RegWrite_i = 1; ALUOp_i = 2'b10;
      rs_data_i = 32'h0000_00A5; rd_addr_i = 5'd3;
   endtask

   task automatic check_zero(input string tag, input logic [15:0] cnt);
      check({tag, "_ctrl"},
            {23'd0, RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o,
             MemWrite_o, Branch_o, Jump_o, ExtOp_o, MemRead_o}, 32'd0);
      check({tag, "_aluop"}, {30'd0, ALUOp_o}, 32'd0);
      check({tag, "_data"}, pc4_o | rs_data_o | rt_data_o | imm_o, 32'd0);
      check({tag, "_addr"}, {17'd0, rs_addr_o, rt_addr_o, rd_addr_o}, 32'd0);
      check({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
      check({tag, "_cnt"}, {16'd0, bubble_cnt_o}, {16'd0, cnt});
   endtask

   task automatic check_a5(input string tag, input logic [15:0] cnt);
      check({tag, "_regwr"}, {31'd0, RegWrite_o}, 32'd1);
      check({tag, "_aluop"}, {30'd0, ALUOp_o}, 32'd2);
      check({tag, "_rs"}, rs_data_o, 32'h0000_00A5);
      check({tag, "_rd"}, {27'd0, rd_addr_o}, 32'd3);
      check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, "_cnt"}, {16'd0, bubble_cnt_o}, {16'd0, cnt});
   endtask

   initial begin
      idle_inputs();
      rs_data_i = 32'h1234_5678; RegWrite_i = 1;
      rst_i = 1;
      step();
      check_zero("reset", 16'd0);

      load_a5();
      step();
      check_a5("load", 16'd0);

      stall_i = 1; rs_data_i = 32'hFFFF_FFFF; hazard_i = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_a5("stall", 16'd0);
      end

      idle_inputs();
      flush_i = 1; stall_i = 1; MemRead_i = 1;
      rs_data_i = 32'hDEAD_BEEF; rd_addr_i = 5'd9;
      step();
      check_zero("flush_stall", 16'd1);

      idle_inputs();
      hazard_i = 1; rs_data_i = 32'h0000_0011; rt_addr_i = 5'd7;
      step();
      check("haz1_cnt", {16'd0, bubble_cnt_o}, 32'd2);
      step();
      check("haz2_valid", {31'd0, valid_o}, 32'd0);
      check("haz2_cnt", {16'd0, bubble_cnt_o}, 32'd3);
      check("haz2_rs", rs_data_o, 32'h0000_0011);
      check("haz2_rt", {27'd0, rt_addr_o}, 32'd7);

      flush_i = 1;
      step();
      check_zero("haz_flush", 16'd4);

      idle_inputs();
      flush_i = 1;
      step();
      check("flush_cnt5", {16'd0, bubble_cnt_o}, 32'd5);

      load_a5();
      pc4_i = 32'h0000_0104; imm_i = 32'hFFFF_FFF0;
      step();
      check_a5("load2", 16'd5);
      check("load2_pc4", pc4_o, 32'h0000_0104);
      check("load2_imm", imm_o, 32'hFFFF_FFF0);

      stall_i = 1; rst_i = 1;
      step();
      check_zero("rst_stall", 16'd0);

      load_a5();
      step();
      check_a5("post_rst", 16'd0);

      idle_inputs();
      rst_i = 1;
      step();
      rst_i = 0; flush_i = 1;
      for (int i = 0; i < 65534; i++)
         step();
      check("preload", {16'd0, bubble_cnt_o}, 32'h0000_FFFE);
      for (int i = 0; i < 3; i++) begin
         step();
         check("sat", {16'd0, bubble_cnt_o}, 32'h0000_FFFF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1: reset; synchronous, active-high.
REQ-003 SHALL have port stall_i, input, 1: hold all stored fields this cycle.
REQ-004 SHALL have port flush_i, input, 1: load a bubble this cycle.
REQ-005 SHALL have port hazard_i, input, 1: upstream hazard select; incoming controls are already a bubble. Used only for counting.
REQ-006 SHALL have ports RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemWrite_i, Branch_i, Jump_i, ExtOp_i, MemRead_i, each input, 1: decoded control bits after bubble mux.
REQ-007 SHALL have port ALUOp_i, input, 2: ALU operation class.
REQ-008 SHALL have ports pc4_i, rs_data_i, rt_data_i, imm_i, each input, 32: PC+4, register read data, extended immediate.
REQ-009 SHALL have ports rs_addr_i, rt_addr_i, rd_addr_i, each input, 5: register specifiers.
REQ-010 SHALL have registered outputs with the same names and widths, suffix _o, for every REQ-006..REQ-009 field.
REQ-011 SHALL have port valid_o, output, 1: stage holds a real instruction.
REQ-012 SHALL have port bubble_cnt_o, output, 16: bubbles loaded since reset.

Function
REQ-013 SHALL select per-cycle action with priority rst_i > flush_i > stall_i > load.
REQ-014 On load, SHALL register every input field and set valid_o = ~hazard_i; latency is 1 cycle.
REQ-015 On flush, SHALL clear all control outputs, ALUOp_o (2'b00), and valid_o to 0, zero all data/address outputs, and ignore stall_i.
REQ-016 On stall without flush, SHALL hold every output, including valid_o and bubble_cnt_o, unchanged.
REQ-017 SHALL increment bubble_cnt_o by 1 on a flush cycle, or on a load cycle with hazard_i = 1. A simultaneous flush_i and hazard_i SHALL count once.
REQ-018 SHALL saturate bubble_cnt_o at 16'hFFFF, with no wrap-around.
REQ-019 SHALL NOT count a stall cycle, even when hazard_i = 1.
REQ-020 Outputs SHALL be pure register outputs, with no combinational path from any input to any output.

Reset
REQ-021 With rst_i high at a clock edge, all outputs SHALL become 0 on that edge: controls, ALUOp_o, data, addresses, valid_o, bubble_cnt_o.
REQ-022 Reset SHALL override in-progress stall or flush. The first edge after rst_i falls SHALL perform a normal priority decision.

Structure
REQ-023 ALUOp encodings and field widths (data 32, address 5, counter 16) SHALL live in the shared CPU package.
REQ-024 The 10 control fields SHALL be held in one sub-module, id_ex_ctrl_reg, sharing the clear/hold logic. Data fields and the counter stay in the top module.

Verification
REQ-025 Load: RegWrite_i=1, ALUOp_i=2'b10, rs_data_i=32'h0000_00A5, rd_addr_i=5'd3, no stall/flush. The next edge SHALL give RegWrite_o=1, ALUOp_o=2'b10, rs_data_o=32'h0000_00A5, rd_addr_o=3, valid_o=1.
REQ-026 Stall: after REQ-025, hold stall_i=1 for 3 cycles while changing rs_data_i to 32'hFFFF_FFFF. Outputs SHALL remain 32'h0000_00A5, and bubble_cnt_o SHALL remain unchanged.
REQ-027 Flush+stall: flush_i=1 and stall_i=1 together with MemRead_i=1. The next edge SHALL give all outputs 0 except bubble_cnt_o, which increments by 1.
REQ-028 Hazard: hazard_i=1 with all-zero controls for 2 load cycles. The result SHALL be valid_o=0 and bubble_cnt_o +2. Adding flush_i in the same cycle SHALL give +1 only.
REQ-029 Saturation: preload counter to 16'hFFFE, then flush for 3 cycles. The counter SHALL read 16'hFFFF, 16'hFFFF, 16'hFFFF.
REQ-030 Reset mid-stall: with stall_i=1, valid_o=1, count=5, assert rst_i for 1 cycle. The next edge SHALL give all outputs 0, and the following load SHALL behave per REQ-025.
